// File: rtl/pc_branch_redirect_pkg.sv
// pc_pkg: shared state encoding and defaults for the PC / fetch-redirect stage
package pc_pkg;
    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } pc_state_e;
    localparam int          ALIGN_LSB       = 2;
    localparam int          DEF_INSTR_BYTES = 1 << ALIGN_LSB;
    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
endpackage

// File: rtl/pc_branch_redirect_sat_counter.sv
// sat_counter: saturating up-counter with asynchronous active-low clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    // count up on inc, sticking at all-ones
    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n)
            count <= '0;
        else if (inc && count != '1)
            count <= count + CNT_W'(1);
endmodule

// File: rtl/pc_branch_redirect.sv
// pc_branch_redirect: PC register with sequential step, stall hold, branch redirect, flush and halt
module pc_branch_redirect
    import pc_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_PC     = PC_W'(DEF_RESET_PC),
    parameter int              INSTR_BYTES  = DEF_INSTR_BYTES,
    parameter int              FLUSH_CYCLES = 2,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [PC_W-1:0]  pc,
    output logic             if_valid,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             misalign_err,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             halted
);
    localparam int LSB = $clog2(INSTR_BYTES);

    logic [1:0]      sync_q;
    pc_state_e       state, state_nx;
    logic [PC_W-1:0] pc_nx;
    logic [2:0]      bub, bub_nx;
    logic            err_nx, inc, flush;

    // two-flop synchroniser: assert is immediate, release reaches the FSM two edges later
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            sync_q <= 2'b00;
        else
            sync_q <= {sync_q[0], 1'b1};

    // next-state, next-pc and per-cycle outputs
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        bub_nx   = bub;
        err_nx   = misalign_err;
        inc      = 1'b0;
        flush    = 1'b0;
        if_valid = 1'b0;
        halted   = 1'b0;
        case (state)
            ST_START: state_nx = sync_q[1] ? ST_RUN : ST_START;
            ST_RUN: begin
                if_valid = !stall;
                if (br_taken) begin
                    flush = 1'b1;
                    if (|br_target[LSB-1:0]) begin
                        err_nx   = 1'b1;
                        state_nx = ST_HALT;
                    end else begin
                        pc_nx    = br_target;
                        inc      = 1'b1;
                        bub_nx   = 3'(FLUSH_CYCLES - 1);
                        state_nx = ST_FLUSH;
                    end
                end else if (halt_req)
                    state_nx = ST_HALT;
                else if (!stall)
                    pc_nx = pc + PC_W'(INSTR_BYTES);
            end
            ST_FLUSH: begin
                state_nx = (bub == 3'd0) ? ST_RUN : ST_FLUSH;
                bub_nx   = (bub == 3'd0) ? bub : bub - 3'd1;
            end
            ST_HALT: begin
                halted   = 1'b1;
                state_nx = (resume && !misalign_err) ? ST_RUN : ST_HALT;
            end
            default: state_nx = ST_START;
        endcase
    end

    assign flush_if_id = flush;
    assign flush_id_ex = flush;

    // state, pc, bubble counter and sticky error register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= ST_START;
            pc           <= RESET_PC;
            bub          <= 3'd0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            bub          <= bub_nx;
            misalign_err <= err_nx;
        end

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (inc),
        .count (taken_cnt)
    );
endmodule

// File: tb/tb_pc_branch_redirect.sv
// tb_pc_branch_redirect: randomized scoreboard bench with a cycle-level reference model
module tb_pc_branch_redirect;
    localparam int IB  = 4;
    localparam int FC  = 2;
    localparam int CMX = 15;

    typedef struct {
        logic [31:0] pc;
        bit          valid;
        bit          flush;
        bit          err;
        int          cnt;
        bit          halted;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, br_taken = 1'b0, halt_req = 1'b0, resume = 1'b0;
    logic [31:0] br_target = '0;
    logic [31:0] pc;
    logic        if_valid, flush_if_id, flush_id_ex, misalign_err, halted;
    logic [3:0]  taken_cnt;

    bit          rst_n_drv = 1'b0;
    exp_t        sb[$];
    int          total = 0, passed = 0;

    logic [31:0] m_pc = '0;
    bit          m_err = 0, m_halt = 0;
    int          m_cnt = 0, m_bub = 0, m_start = 0;

    pc_branch_redirect #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .halt_req(halt_req), .resume(resume), .pc(pc), .if_valid(if_valid),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .misalign_err(misalign_err),
        .taken_cnt(taken_cnt), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
        else passed++;
    endtask

    task automatic model_reset();
        m_pc = '0; m_err = 0; m_halt = 0; m_cnt = 0; m_bub = 0; m_start = 0;
    endtask

    // one clock cycle: drive inputs, predict this cycle's outputs, advance the model
    task automatic step(input bit s, input bit b, input logic [31:0] t, input bit h, input bit r);
        exp_t e;
        @(negedge clk);
        if (!rst_n && rst_n_drv) m_start = 3;
        rst_n = rst_n_drv;
        stall = s; br_taken = b; br_target = t; halt_req = h; resume = r;
        e.pc = m_pc; e.err = m_err; e.cnt = m_cnt;
        e.valid = 0; e.flush = 0; e.halted = 0;
        if (!rst_n) begin
        end else if (m_start > 0) m_start--;
        else if (m_bub > 0) m_bub--;
        else if (m_halt) begin
            e.halted = 1;
            if (r && !m_err) m_halt = 0;
        end else begin
            e.valid = !s;
            if (b) begin
                e.flush = 1;
                if (t % IB != 0) begin
                    m_err = 1; m_halt = 1;
                end else begin
                    m_pc = t; m_bub = FC;
                    m_cnt = (m_cnt >= CMX) ? CMX : m_cnt + 1;
                end
            end else if (h) m_halt = 1;
            else if (!s) m_pc = m_pc + IB;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, $urandom, 0, 0);
    endtask

    // assert reset between clock edges and confirm outputs clear before any edge
    task automatic async_rst();
        @(negedge clk);
        #3;
        rst_n = 0; rst_n_drv = 0;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_valid", {31'b0, if_valid}, 0);
        check("arst_flush", {30'b0, flush_if_id, flush_id_ex}, 0);
        check("arst_err", {31'b0, misalign_err}, 0);
        check("arst_cnt", {28'b0, taken_cnt}, 0);
        check("arst_halted", {31'b0, halted}, 0);
        model_reset();
        idle(2);
        rst_n_drv = 1;
    endtask

    // monitor: every cycle the DUT presents outputs, compare against the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pc", pc, e.pc);
            check("if_valid", {31'b0, if_valid}, {31'b0, e.valid});
            check("flush_if_id", {31'b0, flush_if_id}, {31'b0, e.flush});
            check("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, e.flush});
            check("misalign_err", {31'b0, misalign_err}, {31'b0, e.err});
            check("taken_cnt", {28'b0, taken_cnt}, e.cnt);
            check("halted", {31'b0, halted}, {31'b0, e.halted});
        end
    end

    initial begin
        logic [31:0] t;
        idle(2);
        rst_n_drv = 1;
        idle(7);
        step(0, 1, 32'h100, 0, 0);
        step(0, 1, 32'h200, 0, 0);
        idle(3);
        step(1, 1, 32'h300, 0, 0);
        idle(3);
        step(0, 1, 32'hFFFF_FFF8, 0, 0);
        idle(5);
        step(0, 0, 0, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 1);
        idle(2);
        for (int i = 0; i < 17; i++) begin
            step(0, 1, $urandom & 32'hFFFF_FFFC, 0, 0);
            idle(2);
        end
        step(0, 1, 32'h400, 0, 0);
        async_rst();
        idle(5);
        step(0, 1, 32'h102, 0, 0);
        idle(1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        async_rst();
        idle(4);
        for (int i = 0; i < 600; i++) begin
            if (i % 80 == 79) async_rst();
            t = $urandom;
            if ($urandom_range(3) != 0) t = t & 32'hFFFF_FFFC;
            step($urandom_range(3) == 0, $urandom_range(5) == 0, t,
                 $urandom_range(19) == 0, $urandom_range(2) == 0);
        end
        repeat (2) @(negedge clk);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
